// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: reset levels, bus widths, aluop codes
// and small decode helpers used by the load/store unit and its lane logic.
package mem_access_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP   = 8'b1110_1011;

    // Access width implied by an aluop; ACC_NONE marks a non-memory op.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_BYTE = 2'd1,
        ACC_HALF = 2'd2,
        ACC_WORD = 2'd3
    } acc_size_e;

    function automatic acc_size_e op_size(input logic [AluOpBus-1:0] op);
        acc_size_e sz;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = ACC_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = ACC_HALF;
            EXE_LW_OP, EXE_SW_OP:             sz = ACC_WORD;
            default:                          sz = ACC_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
        logic ld;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: ld = 1'b1;
            default:                                                 ld = 1'b0;
        endcase
        return ld;
    endfunction

    function automatic logic is_signed_load(input logic [AluOpBus-1:0] op);
        logic sg;
        case (op)
            EXE_LB_OP, EXE_LH_OP: sg = 1'b1;
            default:              sg = 1'b0;
        endcase
        return sg;
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Big-endian lane steering for the MEM stage: byte enables, store-data
// replication, load extraction/extension and the misalignment check.
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [RegBus-1:0]   reg2_i,
    input  logic [RegBus-1:0]   load_word_i,
    output logic                is_mem_o,
    output logic                is_load_o,
    output logic                misaligned_o,
    output logic [3:0]          be_o,
    output logic [RegBus-1:0]   wdata_o,
    output logic [RegBus-1:0]   load_data_o
);

    acc_size_e   size_s;
    logic        sign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Decode the access width and steer lanes; offset 0 maps to bits 31:24.
    always_comb begin
        size_s       = op_size(aluop_i);
        sign_s       = is_signed_load(aluop_i);
        is_load_o    = is_load_op(aluop_i);
        is_mem_o     = (size_s != ACC_NONE);
        misaligned_o = 1'b0;
        be_o         = 4'b0000;
        wdata_o      = {RegBus{1'b0}};
        load_data_o  = {RegBus{1'b0}};
        byte_s       = 8'h00;
        half_s       = 16'h0000;
        case (size_s)
            ACC_BYTE: begin
                wdata_o = {4{reg2_i[7:0]}};
                case (addr_lo_i)
                    2'b00:   begin be_o = 4'b1000; byte_s = load_word_i[31:24]; end
                    2'b01:   begin be_o = 4'b0100; byte_s = load_word_i[23:16]; end
                    2'b10:   begin be_o = 4'b0010; byte_s = load_word_i[15:8];  end
                    2'b11:   begin be_o = 4'b0001; byte_s = load_word_i[7:0];   end
                    default: begin be_o = 4'b0000; byte_s = 8'h00;              end
                endcase
                load_data_o = {{24{sign_s & byte_s[7]}}, byte_s};
            end
            ACC_HALF: begin
                misaligned_o = addr_lo_i[0];
                wdata_o      = {2{reg2_i[15:0]}};
                if (addr_lo_i[1]) begin
                    be_o   = 4'b0011;
                    half_s = load_word_i[15:0];
                end else begin
                    be_o   = 4'b1100;
                    half_s = load_word_i[31:16];
                end
                load_data_o = {{16{sign_s & half_s[15]}}, half_s};
            end
            ACC_WORD: begin
                misaligned_o = |addr_lo_i;
                be_o         = 4'b1111;
                wdata_o      = reg2_i;
                load_data_o  = load_word_i;
            end
            default: begin
                misaligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: passes non-memory ops through combinationally,
// runs a request/acknowledge access with a bounded wait for loads/stores,
// and stalls the pipeline while the access is outstanding.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  stallreq_o,
    output logic                  addr_err_o,
    output logic                  bus_err_o,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [3:0]            dm_be_o,
    output logic [RegBus-1:0]     dm_addr_o,
    output logic [RegBus-1:0]     dm_wdata_o,
    input  logic                  dm_ack_i,
    input  logic [RegBus-1:0]     dm_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [RegBus-1:0] load_q, load_d;
    logic              err_q, err_d;

    logic              is_mem_s;
    logic              is_load_s;
    logic              misaligned_s;
    logic              access_ok_s;
    logic [3:0]        be_s;
    logic [RegBus-1:0] lane_wdata_s;
    logic [RegBus-1:0] lane_load_s;
    logic [7:0]        cnt_inc_s;

    mem_lane u_lane (
        .aluop_i      (aluop_i),
        .addr_lo_i    (mem_addr_i[1:0]),
        .reg2_i       (reg2_i),
        .load_word_i  (load_q),
        .is_mem_o     (is_mem_s),
        .is_load_o    (is_load_s),
        .misaligned_o (misaligned_s),
        .be_o         (be_s),
        .wdata_o      (lane_wdata_s),
        .load_data_o  (lane_load_s)
    );

    // Next-state and output logic; reset level forces every output low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_d      = load_q;
        err_d       = err_q;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        addr_err_o  = 1'b0;
        bus_err_o   = 1'b0;
        dm_req_o    = 1'b0;
        dm_we_o     = 1'b0;
        dm_be_o     = 4'b0000;
        dm_addr_o   = {RegBus{1'b0}};
        dm_wdata_o  = {RegBus{1'b0}};
        access_ok_s = is_mem_s & ~misaligned_s;
        cnt_inc_s   = cnt_q + 8'd1;

        // Bus address/data/enables depend only on the held EX/MEM inputs,
        // so they stay stable for the whole access.
        if (access_ok_s) begin
            dm_we_o    = ~is_load_s;
            dm_be_o    = be_s;
            dm_addr_o  = {mem_addr_i[31:2], 2'b00};
            dm_wdata_o = lane_wdata_s;
        end else begin
            dm_we_o    = 1'b0;
            dm_be_o    = 4'b0000;
        end

        if (is_mem_s && misaligned_s) begin
            addr_err_o = 1'b1;
            wreg_o     = 1'b0;
        end else begin
            addr_err_o = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (access_ok_s) begin
                    dm_req_o   = 1'b1;
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                    cnt_d      = 8'd0;
                    err_d      = 1'b0;
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                dm_req_o   = 1'b1;
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
                cnt_d      = cnt_inc_s;
                if (dm_ack_i) begin
                    load_d  = dm_rdata_i;
                    state_d = S_DONE;
                end else if (cnt_inc_s == MAX_WAIT_C) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                bus_err_o = err_q;
                err_d     = 1'b0;
                state_d   = S_IDLE;
                if (err_q) begin
                    wreg_o = 1'b0;
                end else if (is_load_s) begin
                    wdata_o = lane_load_s;
                end else begin
                    wdata_o = wdata_i;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst == RstEnable) begin
            wd_o       = {RegAddrBus{1'b0}};
            wreg_o     = 1'b0;
            wdata_o    = {RegBus{1'b0}};
            stallreq_o = 1'b0;
            addr_err_o = 1'b0;
            bus_err_o  = 1'b0;
            dm_req_o   = 1'b0;
            dm_we_o    = 1'b0;
            dm_be_o    = 4'b0000;
            dm_addr_o  = {RegBus{1'b0}};
            dm_wdata_o = {RegBus{1'b0}};
        end else begin
            stallreq_o = stallreq_o;
        end
    end

    // State, wait counter, load register and error flag with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            load_q  <= {RegBus{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

endmodule
